// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Memory stage of the 5-stage RV32I pipeline. It takes the EX/M register
// outputs, runs the data-memory access over a valid/ready handshake (byte-lane
// alignment, load sign/zero extension, wait-state timeout), selects the
// writeback value and registers it into the M/W pipeline register. While an
// access is outstanding it holds the upstream registers with stall_m.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   valid_m ..          EX/M register outputs (address/ALU result, store data,
//   result_src_m        rd, PC+4, control, funct3, result select)
//   dmem_req/we/addr/   data-memory request; addr is word aligned, wdata and
//   wdata/be            be are lane aligned
//   dmem_ready/rdata    memory completion and read data
//   stall_m             hold IF/ID/EX/M while the access is pending
//   valid_w .. bus_err_w  M/W pipeline register outputs
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int MAX_WAIT = 16,  // cycles allowed in WAIT before abort (1..255)
    parameter int CNT_W    = 8    // wait counter width, 2**CNT_W > MAX_WAIT
) (
    input  logic        clk,
    input  logic        reset,
    // EX/M register outputs
    input  logic        valid_m,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] write_data_m,
    input  logic [4:0]  rd_m,
    input  logic [31:0] pc_plus_4_m,
    input  logic        reg_write_m,
    input  logic        mem_read_m,
    input  logic        mem_write_m,
    input  logic [2:0]  funct3_m,
    input  logic [1:0]  result_src_m,
    // data memory
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    // pipeline control
    output logic        stall_m,
    // M/W register
    output logic        valid_w,
    output logic        reg_write_w,
    output logic [4:0]  rd_w,
    output logic [31:0] result_w,
    output logic        fault_w,
    output logic        bus_err_w
);

    typedef enum logic {IDLE, WAIT} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // ------------------------------------------------------------------
    // Access decode and fault detection
    // ------------------------------------------------------------------
    logic       access;
    logic       is_store;
    logic       illegal_f3;
    logic       misaligned;
    logic       fault;
    logic       abort;
    logic [1:0] off;
    logic [1:0] size;

    assign access   = valid_m & (mem_read_m | mem_write_m);
    // Read and write both set is treated as a store.
    assign is_store = mem_write_m;
    assign off      = alu_result_m[1:0];
    assign size     = funct3_m[1:0];

    always_comb begin
        illegal_f3 = 1'b0;
        if (is_store) begin
            // SB/SH/SW only
            illegal_f3 = funct3_m[2] | (size == 2'b11);
        end else begin
            // LB/LH/LW/LBU/LHU only
            illegal_f3 = (size == 2'b11) | (funct3_m == 3'b110);
        end
    end

    assign misaligned = ((size == 2'b01) & off[0]) |
                        ((size == 2'b10) & (off != 2'b00));

    assign fault = access & (illegal_f3 | misaligned);

    // Timeout: still not ready after MAX_WAIT cycles spent in WAIT.
    assign abort = (state_q == WAIT) & access & ~fault & ~dmem_ready &
                   (wait_cnt_q == CNT_W'(MAX_WAIT));

    // Reset gates the request combinationally so it drops in the very cycle
    // reset asserts, not at the next edge.
    assign dmem_req = ~reset & access & ~fault & ~abort;
    assign stall_m  = dmem_req & ~dmem_ready;
    assign dmem_we  = dmem_req & is_store;

    // ------------------------------------------------------------------
    // Byte-lane alignment
    // ------------------------------------------------------------------
    assign dmem_addr = {alu_result_m[31:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = write_data_m;
        case (size)
            2'b00: begin
                dmem_be    = 4'b0001 << off;
                dmem_wdata = {4{write_data_m[7:0]}};
            end
            2'b01: begin
                dmem_be    = 4'b0011 << off;
                dmem_wdata = {2{write_data_m[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = write_data_m;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load extraction: shift the addressed lane down to bit 0, then extend.
    // ------------------------------------------------------------------
    logic [31:0] lane_word;
    logic [31:0] load_val;

    assign lane_word = dmem_rdata >> {off, 3'b000};

    always_comb begin
        load_val = dmem_rdata;
        case (funct3_m)
            3'b000:  load_val = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b100:  load_val = {24'd0, lane_word[7:0]};
            3'b001:  load_val = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b101:  load_val = {16'd0, lane_word[15:0]};
            default: load_val = dmem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (stall_m) begin
                    state_d    = WAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            WAIT: begin
                if (stall_m) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end else begin
                    // completion, abort, or the access vanished
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // M/W pipeline register
    // ------------------------------------------------------------------
    logic        valid_w_q,     valid_w_d;
    logic        reg_write_w_q, reg_write_w_d;
    logic [4:0]  rd_w_q,        rd_w_d;
    logic [31:0] result_w_q,    result_w_d;
    logic        fault_w_q,     fault_w_d;
    logic        bus_err_w_q,   bus_err_w_d;

    always_comb begin
        valid_w_d     = valid_w_q;
        reg_write_w_d = reg_write_w_q;
        rd_w_d        = rd_w_q;
        result_w_d    = result_w_q;
        fault_w_d     = fault_w_q;
        bus_err_w_d   = bus_err_w_q;
        if (stall_m) begin
            // bubble; rd/result keep their last value
            valid_w_d     = 1'b0;
            reg_write_w_d = 1'b0;
            fault_w_d     = 1'b0;
            bus_err_w_d   = 1'b0;
        end else begin
            valid_w_d     = valid_m;
            // stores never write rd, neither do faulted or aborted accesses
            reg_write_w_d = valid_m & reg_write_m & ~fault & ~abort & ~is_store;
            rd_w_d        = rd_m;
            fault_w_d     = fault;
            bus_err_w_d   = abort;
            case (result_src_m)
                2'b01:   result_w_d = load_val;
                2'b10:   result_w_d = pc_plus_4_m;
                default: result_w_d = alu_result_m;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_w_q     <= 1'b0;
            reg_write_w_q <= 1'b0;
            rd_w_q        <= '0;
            result_w_q    <= '0;
            fault_w_q     <= 1'b0;
            bus_err_w_q   <= 1'b0;
        end else begin
            valid_w_q     <= valid_w_d;
            reg_write_w_q <= reg_write_w_d;
            rd_w_q        <= rd_w_d;
            result_w_q    <= result_w_d;
            fault_w_q     <= fault_w_d;
            bus_err_w_q   <= bus_err_w_d;
        end
    end

    assign valid_w     = valid_w_q;
    assign reg_write_w = reg_write_w_q;
    assign rd_w        = rd_w_q;
    assign result_w    = result_w_q;
    assign fault_w     = fault_w_q;
    assign bus_err_w   = bus_err_w_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
//
// Directed bench for mem_access_stage (built with MAX_WAIT=4). A transaction-
// level model tracks how long the current access has been pending and what
// the M/W register should hold; every cycle the DUT outputs are compared to
// it, and each directed case also pins hand-computed literal results.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_m, reg_write_m, mem_read_m, mem_write_m;
    logic [31:0] alu_result_m, write_data_m, pc_plus_4_m;
    logic [4:0]  rd_m;
    logic [2:0]  funct3_m;
    logic [1:0]  result_src_m;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        stall_m, valid_w, reg_write_w, fault_w, bus_err_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;

    always #5 clk = ~clk;

    mem_access_stage #(.MAX_WAIT(MAXW), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .valid_m(valid_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
        .rd_m(rd_m), .pc_plus_4_m(pc_plus_4_m), .reg_write_m(reg_write_m),
        .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .funct3_m(funct3_m),
        .result_src_m(result_src_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .stall_m(stall_m),
        .valid_w(valid_w), .reg_write_w(reg_write_w), .rd_w(rd_w),
        .result_w(result_w), .fault_w(fault_w), .bus_err_w(bus_err_w)
    );

    int n_tot  = 0;
    int n_pass = 0;

    // ---------------- model state ----------------
    int          pend  = 0;   // cycles the current access has already stalled
    logic        mv    = 1'b0;
    logic        mrw   = 1'b0;
    logic        mflt  = 1'b0;
    logic        mberr = 1'b0;
    logic [4:0]  mrd   = '0;
    logic [31:0] mres  = '0;

    // What the bus side must look like this cycle, from the rules of the ISA
    // and handshake: legality by set membership, alignment by modulo of the
    // access size, lanes and extension by arithmetic.
    function automatic void model_comb(output bit rq, output bit st, output bit ab,
                                       output bit fl, output logic [3:0] b,
                                       output logic [31:0] wd, output logic [31:0] lv);
        int          nb;
        logic [1:0]  o;
        bit          acc, legal;
        logic [31:0] raw, msk;
        acc = valid_m && (mem_read_m || mem_write_m);
        if (mem_write_m) legal = funct3_m inside {3'b000, 3'b001, 3'b010};
        else             legal = funct3_m inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        nb = 1 << funct3_m[1:0];
        o  = alu_result_m[1:0];
        fl = acc && (!legal || (alu_result_m[1:0] % nb) != 0);
        ab = acc && !fl && (pend == MAXW) && !dmem_ready;
        rq = acc && !fl && !ab && !reset;
        st = rq && !dmem_ready;
        b  = 4'(((1 << nb) - 1) << o);
        if (nb == 1)      wd = write_data_m[7:0] * 32'h0101_0101;
        else if (nb == 2) wd = write_data_m[15:0] * 32'h0001_0001;
        else              wd = write_data_m;
        raw = dmem_rdata >> (8 * o);
        if (nb >= 4) lv = dmem_rdata;
        else begin
            msk = (32'd1 << (8 * nb)) - 32'd1;
            lv  = raw & msk;
            if (!funct3_m[2] && lv[8*nb-1]) lv = lv | ~msk;
        end
    endfunction

    always @(posedge clk or posedge reset) begin : mdl
        bit          rq, st, ab, fl;
        logic [3:0]  b;
        logic [31:0] wd, lv;
        if (reset) begin
            pend = 0; mv = 0; mrw = 0; mflt = 0; mberr = 0; mrd = '0; mres = '0;
        end else begin
            model_comb(rq, st, ab, fl, b, wd, lv);
            if (st) begin
                pend = pend + 1;
                mv = 0; mrw = 0; mflt = 0; mberr = 0;
            end else begin
                pend  = 0;
                mv    = valid_m;
                mrw   = valid_m && reg_write_m && !fl && !ab && !mem_write_m;
                mrd   = rd_m;
                mflt  = fl;
                mberr = ab;
                if (result_src_m == 2'b10)      mres = pc_plus_4_m;
                else if (result_src_m == 2'b01) mres = lv;
                else                            mres = alu_result_m;
            end
        end
    end

    // ---------------- checking ----------------
    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endfunction

    task automatic compare_cycle();
        bit          rq, st, ab, fl;
        logic [3:0]  b;
        logic [31:0] wd, lv;
        model_comb(rq, st, ab, fl, b, wd, lv);
        chk("dmem_req", dmem_req, rq);
        chk("stall_m", stall_m, st);
        chk("dmem_we", dmem_we, rq && mem_write_m);
        if (rq) begin
            chk("dmem_addr", dmem_addr, alu_result_m & ~32'd3);
            chk("dmem_be", dmem_be, b);
            if (mem_write_m) chk("dmem_wdata", dmem_wdata, wd);
        end
        chk("valid_w", valid_w, mv);
        chk("reg_write_w", reg_write_w, mrw);
        chk("rd_w", rd_w, mrd);
        chk("result_w", result_w, mres);
        chk("fault_w", fault_w, mflt);
        chk("bus_err_w", bus_err_w, mberr);
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_m = 0; reg_write_m = 0; mem_read_m = 0; mem_write_m = 0;
        alu_result_m = '0; write_data_m = '0; pc_plus_4_m = '0; rd_m = '0;
        funct3_m = '0; result_src_m = '0; dmem_ready = 0; dmem_rdata = '0;
    endtask

    // Presents one instruction and holds it while stall_m is high. Ready is
    // raised once the access has stalled rdy_after cycles.
    task automatic do_op(input logic rd_en, input logic wr_en, input logic rw,
                         input logic [2:0] f3, input logic [1:0] src,
                         input logic [31:0] addr, input logic [31:0] wdat,
                         input logic [31:0] pc4, input logic [31:0] rdat,
                         input logic [4:0] rd, input int rdy_after,
                         output int stalls, output logic req0,
                         output logic [3:0] be0, output logic [31:0] wd0);
        bit   done;
        logic s;
        done = 0;
        valid_m = 1; mem_read_m = rd_en; mem_write_m = wr_en; reg_write_m = rw;
        funct3_m = f3; result_src_m = src; alu_result_m = addr; write_data_m = wdat;
        pc_plus_4_m = pc4; rd_m = rd; dmem_rdata = rdat; dmem_ready = (rdy_after == 0);
        stalls = 0; req0 = 0; be0 = '0; wd0 = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            compare_cycle();
            if (c == 0) begin req0 = dmem_req; be0 = dmem_be; wd0 = dmem_wdata; end
            s = stall_m;
            @(posedge clk);
            #1;
            if (s !== 1'b1) done = 1;
            else begin
                stalls++;
                dmem_ready = (stalls >= rdy_after);
            end
        end
        if (!done) begin
            n_tot++;
            $display("FAIL op_release: still stalled after 40 cycles, expected release");
        end
        idle_inputs();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int          st;
        logic        r;
        logic [3:0]  b;
        logic [31:0] w;

        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        tick();
        chk("rst_valid_w", valid_w, 0);
        chk("rst_result_w", result_w, 0);
        reset = 0;
        tick();
        tick();

        // zero-wait LB, lane 3, sign-extended
        do_op(1, 0, 1, 3'b000, 2'b01, 32'h1003, 0, 0, 32'h80FF_0000, 5'd5, 0, st, r, b, w);
        chk("lb_req", r, 1);
        chk("lb_be", b, 4'b1000);
        chk("lb_stalls", st, 0);
        chk("lb_result_w", result_w, 32'hFFFF_FF80);
        chk("lb_reg_write_w", reg_write_w, 1);
        chk("lb_model_pin", mres, 32'hFFFF_FF80);
        tick();

        // two-wait SH at lane 2
        do_op(0, 1, 1, 3'b001, 2'b00, 32'h2002, 32'h1234_ABCD, 0, 0, 5'd6, 2, st, r, b, w);
        chk("sh_be", b, 4'b1100);
        chk("sh_wdata", w, 32'hABCD_ABCD);
        chk("sh_stalls", st, 2);
        chk("sh_valid_w", valid_w, 1);
        chk("sh_reg_write_w", reg_write_w, 0);
        tick();

        // misaligned LW: no request even with ready high
        do_op(1, 0, 1, 3'b010, 2'b01, 32'h3001, 0, 0, 32'h5555_5555, 5'd7, 0, st, r, b, w);
        chk("mis_req", r, 0);
        chk("mis_stalls", st, 0);
        chk("mis_fault_w", fault_w, 1);
        chk("mis_reg_write_w", reg_write_w, 0);
        chk("mis_valid_w", valid_w, 1);

        // timeout with ready held low, then an immediate follow-up LW
        do_op(1, 0, 1, 3'b010, 2'b01, 32'h4000, 0, 0, 0, 5'd8, 1000, st, r, b, w);
        chk("to_stalls", st, MAXW);
        chk("to_bus_err_w", bus_err_w, 1);
        chk("to_reg_write_w", reg_write_w, 0);
        chk("to_valid_w", valid_w, 1);
        do_op(1, 0, 1, 3'b010, 2'b01, 32'h4004, 0, 0, 32'hDEAD_BEEF, 5'd9, 0, st, r, b, w);
        chk("after_to_stalls", st, 0);
        chk("after_to_result_w", result_w, 32'hDEAD_BEEF);
        chk("after_to_reg_write_w", reg_write_w, 1);
        chk("after_to_bus_err_w", bus_err_w, 0);

        // JAL pass-through
        do_op(0, 0, 1, 3'b000, 2'b10, 32'h0, 0, 32'h104, 0, 5'd1, 0, st, r, b, w);
        chk("jal_req", r, 0);
        chk("jal_result_w", result_w, 32'h104);
        chk("jal_rd_w", rd_w, 1);
        chk("jal_reg_write_w", reg_write_w, 1);

        // LHU one wait, LH zero wait
        do_op(1, 0, 1, 3'b101, 2'b01, 32'h5002, 0, 0, 32'h8001_7FFF, 5'd10, 1, st, r, b, w);
        chk("lhu_stalls", st, 1);
        chk("lhu_result_w", result_w, 32'h0000_8001);
        chk("lhu_model_pin", mres, 32'h0000_8001);
        do_op(1, 0, 1, 3'b001, 2'b01, 32'h5000, 0, 0, 32'h1234_8001, 5'd11, 0, st, r, b, w);
        chk("lh_be", b, 4'b0011);
        chk("lh_result_w", result_w, 32'hFFFF_8001);

        // SB lane 1
        do_op(0, 1, 0, 3'b000, 2'b00, 32'h6001, 32'h0000_00A5, 0, 0, 5'd12, 0, st, r, b, w);
        chk("sb_be", b, 4'b0010);
        chk("sb_wdata", w, 32'hA5A5_A5A5);

        // illegal store funct3
        do_op(0, 1, 0, 3'b100, 2'b00, 32'h6100, 32'h1, 0, 0, 5'd13, 0, st, r, b, w);
        chk("ill_req", r, 0);
        chk("ill_fault_w", fault_w, 1);

        // read+write both set acts as SW; result_w left non-zero for reset test
        do_op(1, 1, 1, 3'b010, 2'b00, 32'h7000, 32'h1122_3344, 0, 0, 5'd7, 0, st, r, b, w);
        chk("rw_wdata", w, 32'h1122_3344);
        chk("rw_reg_write_w", reg_write_w, 0);
        chk("rw_result_w", result_w, 32'h7000);

        // reset while an LW has been pending three cycles
        valid_m = 1; mem_read_m = 1; reg_write_m = 1; funct3_m = 3'b010;
        result_src_m = 2'b01; alu_result_m = 32'h8000; rd_m = 5'd14; dmem_ready = 0;
        tick(); tick(); tick();
        chk("pre_rst_stall", stall_m, 1);
        reset = 1;
        #1;
        chk("rst_mid_req", dmem_req, 0);
        chk("rst_mid_stall", stall_m, 0);
        chk("rst_mid_valid_w", valid_w, 0);
        chk("rst_mid_rd_w", rd_w, 0);
        chk("rst_mid_result_w", result_w, 0);
        idle_inputs();
        tick();
        reset = 0;
        tick();
        // back in IDLE: a zero-wait LBU completes without stalling
        do_op(1, 0, 1, 3'b100, 2'b01, 32'h9002, 0, 0, 32'h00AB_0000, 5'd15, 0, st, r, b, w);
        chk("post_rst_stalls", st, 0);
        chk("post_rst_result_w", result_w, 32'h0000_00AB);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
